// File: rtl/snk_video_pkg.sv
// snk_video_pkg: shared line-buffer constants, state type and flip-address helper
package snk_video_pkg;
    localparam logic [31:0] LB_TRANSP_DEFAULT = '1;
    typedef enum logic {LB_INIT, LB_RUN} lb_state_t;
    function automatic int lb_flip_addr(input int x, input int len);
        return len - 1 - x;
    endfunction
endpackage

// File: rtl/snk_lbuf_bank_ram.sv
// snk_lbuf_bank_ram: 2**ADDR_W x PIX_W sync RAM; port a = draw read/commit, port b = display read/clear, reads return pre-write data
module snk_lbuf_bank_ram #(
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              a_re,
    input  logic [ADDR_W-1:0] a_raddr,
    output logic [PIX_W-1:0]  a_q,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_waddr,
    input  logic [PIX_W-1:0]  a_wdata,
    input  logic              b_re,
    input  logic [ADDR_W-1:0] b_raddr,
    output logic [PIX_W-1:0]  b_q,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_waddr,
    input  logic [PIX_W-1:0]  b_wdata
);
    logic [PIX_W-1:0] mem [2**ADDR_W];
    always_ff @(posedge clk) begin
        if (a_re) a_q <= mem[a_raddr];
        if (b_re) b_q <= mem[b_raddr];
        if (a_we) mem[a_waddr] <= a_wdata;
        if (b_we) mem[b_waddr] <= b_wdata;
    end
endmodule

// File: rtl/snk_dual_linebuf.sv
// snk_dual_linebuf: double-buffered sprite line buffer; wr_* draws into draw_bank, rd_* reads/clears the other bank, swap exchanges them, init sweep clears both
module snk_dual_linebuf import snk_video_pkg::*; #(
    parameter int               PIX_W         = 8,
    parameter int               ADDR_W        = 9,
    parameter int               LINE_LEN      = 320,
    parameter logic [PIX_W-1:0] TRANSP        = LB_TRANSP_DEFAULT[PIX_W-1:0],
    parameter bit               FIRST_WINS    = 1'b1,
    parameter bit               CLEAR_ON_READ = 1'b1
) (
    input  logic              clk,
    input  logic              RESETn,
    input  logic              swap,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_x,
    input  logic [PIX_W-1:0]  wr_pix,
    output logic              wr_ready,
    input  logic              rd_cen,
    input  logic [ADDR_W-1:0] rd_x,
    input  logic              flip,
    output logic [PIX_W-1:0]  rd_pix,
    output logic              draw_bank,
    output logic              init_done
);
    localparam logic [ADDR_W:0] LEN = (ADDR_W+1)'(LINE_LEN);
    lb_state_t         state;
    logic [ADDR_W-1:0] sweep;
    logic              s1_v, s1_bank, s2_v, s2_bank;
    logic [ADDR_W-1:0] s1_x, s2_x;
    logic [PIX_W-1:0]  s1_pix, s2_val, old;
    logic              r_oor, r_bank, clr_v;
    logic [ADDR_W-1:0] r_addr, rd_addr;
    logic [PIX_W-1:0]  a_q [2];
    logic [PIX_W-1:0]  b_q [2];
    logic              init, accept, s1_we, rd_go, rd_in;
    assign init    = state == LB_INIT;
    assign accept  = wr_en && !init;
    assign old     = (s2_v && s2_bank == s1_bank && s2_x == s1_x) ? s2_val : a_q[s1_bank];
    assign s1_we   = s1_v && {1'b0, s1_x} < LEN && s1_pix != TRANSP && (!FIRST_WINS || old == TRANSP);
    assign rd_go   = rd_cen && !init;
    assign rd_in   = {1'b0, rd_x} < LEN;
    assign rd_addr = flip ? ADDR_W'(lb_flip_addr(int'(rd_x), LINE_LEN)) : rd_x;
    assign rd_pix  = r_oor ? TRANSP : b_q[r_bank];
    for (genvar i = 0; i < 2; i++) begin : g_bank
        snk_lbuf_bank_ram #(.PIX_W(PIX_W), .ADDR_W(ADDR_W)) u_ram (
            .clk     (clk),
            .a_re    (accept && draw_bank == 1'(i)),
            .a_raddr (wr_x),
            .a_q     (a_q[i]),
            .a_we    (s1_we && s1_bank == 1'(i)),
            .a_waddr (s1_x),
            .a_wdata (s1_pix),
            .b_re    (rd_go && rd_in && draw_bank != 1'(i)),
            .b_raddr (rd_addr),
            .b_q     (b_q[i]),
            .b_we    (init || (clr_v && r_bank == 1'(i))),
            .b_waddr (init ? sweep : r_addr),
            .b_wdata (TRANSP)
        );
    end
    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            state     <= LB_INIT;
            sweep     <= '0;
            init_done <= 1'b0;
            wr_ready  <= 1'b0;
            draw_bank <= 1'b0;
            s1_v      <= 1'b0;
            s1_bank   <= 1'b0;
            s1_x      <= '0;
            s1_pix    <= TRANSP;
            s2_v      <= 1'b0;
            s2_bank   <= 1'b0;
            s2_x      <= '0;
            s2_val    <= TRANSP;
            clr_v     <= 1'b0;
            r_oor     <= 1'b1;
            r_bank    <= 1'b0;
            r_addr    <= '0;
        end else begin
            if (init) sweep <= sweep + 1'b1;
            if (init && &sweep) begin
                state     <= LB_RUN;
                init_done <= 1'b1;
                wr_ready  <= 1'b1;
            end
            if (!init && swap) draw_bank <= ~draw_bank;
            s1_v <= accept;
            if (accept) begin
                s1_x    <= wr_x;
                s1_pix  <= wr_pix;
                s1_bank <= draw_bank;
            end
            s2_v    <= s1_v;
            s2_bank <= s1_bank;
            s2_x    <= s1_x;
            s2_val  <= s1_we ? s1_pix : old;
            clr_v   <= rd_go && rd_in && CLEAR_ON_READ;
            if (rd_go) begin
                r_oor  <= !rd_in;
                r_bank <= ~draw_bank;
                r_addr <= rd_addr;
            end
        end
    end
endmodule

// File: tb/tb_snk_dual_linebuf.sv
// tb_snk_dual_linebuf: scoreboard bench driving a first-wins and a last-wins instance with shared directed stimulus
module tb_snk_dual_linebuf;
    typedef struct packed {
        logic [7:0]  e1;
        logic [7:0]  e0;
        logic [15:0] id;
    } sb_t;
    logic       clk = 1'b0;
    logic       RESETn = 1'b0;
    logic       swap = 1'b0, wr_en = 1'b0, rd_cen = 1'b0, flip = 1'b0;
    logic [8:0] wr_x = '0, rd_x = '0;
    logic [7:0] wr_pix = '0;
    logic       wr_ready1, draw_bank1, init_done1, wr_ready0, draw_bank0, init_done0;
    logic [7:0] rd_pix1, rd_pix0;
    int         vectors = 0, miscompares = 0, n;
    logic [15:0] next_id = '0;
    sb_t        exp_q[$];
    sb_t        mon_e;
    always #5 clk = ~clk;
    snk_dual_linebuf #(.FIRST_WINS(1'b1)) u1 (
        .clk(clk), .RESETn(RESETn), .swap(swap), .wr_en(wr_en), .wr_x(wr_x), .wr_pix(wr_pix),
        .wr_ready(wr_ready1), .rd_cen(rd_cen), .rd_x(rd_x), .flip(flip), .rd_pix(rd_pix1),
        .draw_bank(draw_bank1), .init_done(init_done1)
    );
    snk_dual_linebuf #(.FIRST_WINS(1'b0)) u0 (
        .clk(clk), .RESETn(RESETn), .swap(swap), .wr_en(wr_en), .wr_x(wr_x), .wr_pix(wr_pix),
        .wr_ready(wr_ready0), .rd_cen(rd_cen), .rd_x(rd_x), .flip(flip), .rd_pix(rd_pix0),
        .draw_bank(draw_bank0), .init_done(init_done0)
    );
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic tick(input int k);
        repeat (k) @(negedge clk);
    endtask
    task automatic push(input logic [7:0] e1, input logic [7:0] e0);
        exp_q.push_back('{e1: e1, e0: e0, id: next_id});
        next_id++;
    endtask
    task automatic rd(input int x, input logic fl, input logic [7:0] e1, input logic [7:0] e0);
        rd_cen = 1'b1;
        rd_x   = 9'(x);
        flip   = fl;
        push(e1, e0);
        @(negedge clk);
        rd_cen = 1'b0;
        flip   = 1'b0;
    endtask
    task automatic wr(input int x, input logic [7:0] p);
        wr_en  = 1'b1;
        wr_x   = 9'(x);
        wr_pix = p;
        @(negedge clk);
        wr_en  = 1'b0;
    endtask
    task automatic do_swap();
        swap = 1'b1;
        @(negedge clk);
        swap = 1'b0;
    endtask
    always @(posedge clk) begin
        if (RESETn && rd_cen) begin
            #1;
            if (exp_q.size() == 0) begin
                chk("rd_unexpected", 32'(rd_pix1), 32'hFFFF);
            end else begin
                mon_e = exp_q.pop_front();
                chk($sformatf("rd_pix_first_wins #%0d", mon_e.id), 32'(rd_pix1), 32'(mon_e.e1));
                chk($sformatf("rd_pix_last_wins #%0d", mon_e.id), 32'(rd_pix0), 32'(mon_e.e0));
            end
        end
    end
    initial begin
        tick(3);
        chk("rst_init_done", 32'(init_done1), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready1), 32'd0);
        chk("rst_draw_bank", 32'(draw_bank1), 32'd0);
        chk("rst_rd_pix", 32'(rd_pix1), 32'hFF);
        RESETn = 1'b1;
        tick(100);
        chk("sweep_busy", 32'(init_done1), 32'd0);
        RESETn = 1'b0;
        tick(1);
        chk("midsweep_reset_done", 32'(init_done1), 32'd0);
        RESETn = 1'b1;
        n = 0;
        while (!init_done1 && n < 600) begin
            swap   = (n == 5);
            rd_cen = (n == 10);
            rd_x   = 9'd3;
            if (n == 10) push(8'hFF, 8'hFF);
            @(negedge clk);
            n++;
        end
        swap   = 1'b0;
        rd_cen = 1'b0;
        chk("init_cycles", 32'(n), 32'd512);
        chk("init_done_u0", 32'(init_done0), 32'd1);
        chk("run_wr_ready", 32'(wr_ready1), 32'd1);
        chk("init_swap_ignored", 32'(draw_bank1), 32'd0);
        for (int x = 0; x < 320; x++) rd(x, 1'b0, 8'hFF, 8'hFF);
        do_swap();
        chk("swap_bank1", 32'(draw_bank1), 32'd1);
        for (int x = 0; x < 320; x++) rd(x, 1'b0, 8'hFF, 8'hFF);
        wr(10, 8'h23);
        wr(10, 8'h45);
        tick(3);
        do_swap();
        chk("swap_bank0", 32'(draw_bank1), 32'd0);
        rd(10, 1'b0, 8'h23, 8'h45);
        tick(1);
        rd(10, 1'b0, 8'hFF, 8'hFF);
        wr(11, 8'h23);
        wr(11, 8'hFF);
        tick(3);
        do_swap();
        rd(11, 1'b0, 8'h23, 8'h23);
        wr(0, 8'h07);
        tick(3);
        do_swap();
        rd(319, 1'b1, 8'h07, 8'h07);
        tick(1);
        rd(0, 1'b1, 8'hFF, 8'hFF);
        rd(319, 1'b0, 8'hFF, 8'hFF);
        chk("pre_swap_write_bank", 32'(draw_bank1), 32'd0);
        swap   = 1'b1;
        wr_en  = 1'b1;
        wr_x   = 9'd5;
        wr_pix = 8'h12;
        rd_cen = 1'b1;
        rd_x   = 9'd5;
        push(8'hFF, 8'hFF);
        @(negedge clk);
        swap   = 1'b0;
        wr_en  = 1'b0;
        rd_cen = 1'b0;
        chk("swap_with_write_bank", 32'(draw_bank0), 32'd1);
        tick(3);
        rd(5, 1'b0, 8'h12, 8'h12);
        wr(330, 8'h55);
        rd(400, 1'b0, 8'hFF, 8'hFF);
        tick(3);
        do_swap();
        for (int x = 0; x < 512; x++) rd(x, 1'b0, 8'hFF, 8'hFF);
        do_swap();
        for (int x = 0; x < 512; x++) rd(x, 1'b0, 8'hFF, 8'hFF);
        tick(4);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
